// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment capture path.
//
// Segment bit order everywhere is {g,f,e,d,c,b,a}, active-high:
//   bit 0 = a (top), 1 = b (top right), 2 = c (bottom right),
//   bit 3 = d (bottom), 4 = e (bottom left), 5 = f (top left), 6 = g (middle).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package seg7_pkg;

    localparam int SEG_W   = 7;
    localparam int DIGIT_W = 4;

    // Hex glyphs as driven by the counter/seg7 display source.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;  // lower-case b
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;  // lower-case d
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    // All segments dark: the display is blanked, not showing a digit.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Purely combinational glyph-to-digit lookup.
//
// Ports:
//   i_seg   in  7  segment pattern {g,f,e,d,c,b,a}
//   o_hit   out 1  pattern is one of the 16 legal hex glyphs
//   o_code  out 4  hex value of the glyph (0 when o_hit is low)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]   i_seg,
    output logic               o_hit,
    output logic [DIGIT_W-1:0] o_code
);

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_hit  = 1'b1;
        o_code = '0;
        unique case (i_seg)
            GLYPH_0: o_code = 4'h0;
            GLYPH_1: o_code = 4'h1;
            GLYPH_2: o_code = 4'h2;
            GLYPH_3: o_code = 4'h3;
            GLYPH_4: o_code = 4'h4;
            GLYPH_5: o_code = 4'h5;
            GLYPH_6: o_code = 4'h6;
            GLYPH_7: o_code = 4'h7;
            GLYPH_8: o_code = 4'h8;
            GLYPH_9: o_code = 4'h9;
            GLYPH_A: o_code = 4'hA;
            GLYPH_B: o_code = 4'hB;
            GLYPH_C: o_code = 4'hC;
            GLYPH_D: o_code = 4'hD;
            GLYPH_E: o_code = 4'hE;
            GLYPH_F: o_code = 4'hF;
            default: o_hit  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// ---------------------------------------------------------------------------
// seg7_capture
// Reads a 7-segment pattern from an external display, recovers the hex
// digit it shows and checks that the display counts 0,1,...,F,0 by +1.
// Pipeline: 2-flop synchroniser -> stability filter -> glyph decode ->
// sequence checker.
//
// Ports:
//   clk          in   1  clock
//   rst_n        in   1  asynchronous active-low reset
//   en           in   1  filter enable; low = no acceptance, outputs hold
//   seg_in       in   7  raw segments {g,f,e,d,c,b,a}, asynchronous to clk
//   clear_err    in   1  synchronous clear of skip_err and step_count
//   digit_out    out  4  last accepted valid digit
//   digit_valid  out  1  last accepted pattern was a legal glyph
//   invalid      out  1  last accepted pattern was non-blank and illegal
//   update       out  1  pulse: new digit, or first digit after blank/invalid
//   wrap         out  1  pulse: accepted F->0 step
//   skip_err     out  1  sticky: a digit change was not +1 mod 16
//   step_count   out  8  correct +1 steps, saturating at 255
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4  // legal range 2..15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SEG_W-1:0]   seg_in,
    input  logic               clear_err,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               digit_valid,
    output logic               invalid,
    output logic               update,
    output logic               wrap,
    output logic               skip_err,
    output logic [7:0]         step_count
);

    localparam logic [3:0] CNT_MAX    = 4'(STABLE_CYCLES);
    localparam logic [3:0] CNT_ACCEPT = 4'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]   r_sync1;
    logic [SEG_W-1:0]   r_sync2;
    logic [SEG_W-1:0]   r_cand;
    logic [3:0]         r_cnt;
    logic               r_has_prev;

    logic               w_accept;
    logic               w_hit;
    logic [DIGIT_W-1:0] w_code;
    logic [DIGIT_W-1:0] w_next_digit;
    logic               w_step;
    logic               w_skip;

    // -----------------------------------------------------------------------
    // Synchroniser
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a true 2-stage chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Stability filter
    // The candidate always tracks the synchronised pattern; the counter only
    // advances while enabled. Saturating at STABLE_CYCLES (one past the
    // accept value) gives exactly one accept per stable pattern.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (!en) begin
            r_cnt  <= '0;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt  <= r_cnt + 4'd1;
        end
    end

    assign w_accept = en && (r_sync2 == r_cand) && (r_cnt == CNT_ACCEPT);

    // -----------------------------------------------------------------------
    // Decode the held candidate (equal to r_sync2 whenever w_accept is high)
    // -----------------------------------------------------------------------
    seg7_decode u_decode (
        .i_seg  (r_cand),
        .o_hit  (w_hit),
        .o_code (w_code)
    );

    // Only a change between two legal digits is judged; 4-bit add wraps F->0.
    assign w_next_digit = digit_out + 4'd1;
    assign w_step = r_has_prev && (w_code == w_next_digit);
    assign w_skip = r_has_prev && (w_code != digit_out) && !w_step;

    // -----------------------------------------------------------------------
    // Sequence checker
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_out   <= '0;
            digit_valid <= 1'b0;
            invalid     <= 1'b0;
            update      <= 1'b0;
            wrap        <= 1'b0;
            skip_err    <= 1'b0;
            step_count  <= '0;
            r_has_prev  <= 1'b0;
        end else begin
            update <= 1'b0;
            wrap   <= 1'b0;

            if (w_accept) begin
                if (w_hit) begin
                    digit_out   <= w_code;
                    digit_valid <= 1'b1;
                    invalid     <= 1'b0;
                    r_has_prev  <= 1'b1;
                    if (!r_has_prev || (w_code != digit_out)) begin
                        update <= 1'b1;
                    end
                    if (w_step) begin
                        wrap <= (digit_out == 4'hF);
                        if (step_count != 8'hFF) begin
                            step_count <= step_count + 8'd1;
                        end
                    end
                    if (w_skip) begin
                        skip_err <= 1'b1;
                    end
                end else begin
                    // Blank and illegal patterns both break the chain; the
                    // last good digit stays visible on digit_out.
                    digit_valid <= 1'b0;
                    invalid     <= (r_cand != SEG_BLANK);
                    r_has_prev  <= 1'b0;
                end
            end

            // Placed last so it overrides any step/skip from the same cycle.
            if (clear_err) begin
                step_count <= '0;
                skip_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
`timescale 1ns/1ps
module tb_seg7_capture;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [6:0] seg_in;
    logic       clear_err;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       invalid;
    logic       update;
    logic       wrap;
    logic       skip_err;
    logic [7:0] step_count;

    seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .seg_in      (seg_in),
        .clear_err   (clear_err),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .invalid     (invalid),
        .update      (update),
        .wrap        (wrap),
        .skip_err    (skip_err),
        .step_count  (step_count)
    );

    always #5 clk = ~clk;

    // Reference glyph table, written out independently of the design package.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [3:0] digit;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_bad  = 0;
    int n_upd  = 0;   // update pulses observed
    int n_wrap = 0;   // wrap pulses observed

    // Behavioural model of the checker state.
    logic [3:0] m_digit    = '0;
    logic       m_valid    = 1'b0;
    logic       m_invalid  = 1'b0;
    logic       m_has_prev = 1'b0;
    logic       m_skip     = 1'b0;
    int         m_step     = 0;
    int         m_upd      = 0;
    int         m_wrap     = 0;

    task automatic check(input string tag, input int obs, input int expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_digit    = '0;
        m_valid    = 1'b0;
        m_invalid  = 1'b0;
        m_has_prev = 1'b0;
        m_skip     = 1'b0;
        m_step     = 0;
    endtask

    // Predict the effect of the design accepting pattern pat.
    task automatic model_accept(input logic [6:0] pat);
        int   k;
        exp_t e;
        logic [3:0] kd;
        logic [3:0] nxt;
        k = -1;
        for (int i = 0; i < 16; i++) if (glyph[i] == pat) k = i;
        if (k >= 0) begin
            kd  = 4'(k);
            nxt = m_digit + 4'd1;
            if (!m_has_prev || kd != m_digit) begin
                e.digit = kd;
                e.wrap  = m_has_prev && (kd == nxt) && (m_digit == 4'hF);
                exp_q.push_back(e);
                m_upd++;
                if (e.wrap) m_wrap++;
            end
            if (m_has_prev && kd != m_digit) begin
                if (kd == nxt) begin
                    if (m_step < 255) m_step++;
                end else begin
                    m_skip = 1'b1;
                end
            end
            m_digit    = kd;
            m_valid    = 1'b1;
            m_invalid  = 1'b0;
            m_has_prev = 1'b1;
        end else begin
            m_valid    = 1'b0;
            m_invalid  = (pat != 7'h00);
            m_has_prev = 1'b0;
        end
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_digit"},   int'(digit_out),   int'(m_digit));
        check({tag, "_valid"},   int'(digit_valid), int'(m_valid));
        check({tag, "_invalid"}, int'(invalid),     int'(m_invalid));
        check({tag, "_steps"},   int'(step_count),  m_step);
        check({tag, "_skip"},    int'(skip_err),    int'(m_skip));
        check({tag, "_updates"}, n_upd,             m_upd);
    endtask

    // Drive a pattern from a falling edge and hold it.
    task automatic show(input logic [6:0] pat, input int hold);
        seg_in = pat;
        model_accept(pat);
        repeat (hold) @(negedge clk);
    endtask

    // Scoreboard: each update pulse pops the next predicted digit/wrap.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (update !== 1'b0 || wrap !== 1'b0)) begin
            if (update === 1'b1) n_upd++;
            if (wrap === 1'b1) n_wrap++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_pulse: observed update=%b wrap=%b digit=%0h expected no pulse",
                       update, wrap, digit_out);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_update", int'(update),    1);
                check("pulse_digit",  int'(digit_out), int'(e.digit));
                check("pulse_wrap",   int'(wrap),      int'(e.wrap));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        rst_n     = 1'b0;
        en        = 1'b1;
        seg_in    = 7'h00;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digit",  int'(digit_out),   0);
        check("rst_valid",  int'(digit_valid), 0);
        check("rst_invalid",int'(invalid),     0);
        check("rst_update", int'(update),      0);
        check("rst_wrap",   int'(wrap),        0);
        check("rst_skip",   int'(skip_err),    0);
        check("rst_steps",  int'(step_count),  0);

        // Idle blank after reset.
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_levels("idle");

        // First digit: latency from first sampling edge.
        seg_in = glyph[1];
        model_accept(glyph[1]);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (update === 1'b1) break;
        end
        check("first_latency", n - 1, STABLE + 2);
        repeat (4) @(negedge clk);
        check_levels("first");

        // Blank, then full count 0..F,0.
        show(7'h00, 10);
        check_levels("blank");
        for (int d = 0; d < 16; d++) show(glyph[d], 10);
        show(glyph[0], 10);
        check_levels("seq");
        check("seq_wraps", n_wrap, m_wrap);

        // clear_err coincident with a correct +1 accept (0 -> 1).
        seg_in = glyph[1];
        model_accept(glyph[1]);
        repeat (STABLE + 2) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        m_step = 0;
        m_skip = 1'b0;
        repeat (6) @(negedge clk);
        check_levels("clr_coinc");

        // Step to 4, then a short glitch to 7F and back.
        show(glyph[2], 10);
        show(glyph[3], 10);
        show(glyph[4], 10);
        seg_in = 7'h7F;
        repeat (STABLE - 1) @(negedge clk);
        show(glyph[4], 12);
        check_levels("glitch");

        // 2 then 5: skip detected and sticky.
        show(glyph[2], 10);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        m_step = 0;
        m_skip = 1'b0;
        check("clr_idle_skip", int'(skip_err), int'(m_skip));
        show(glyph[5], 10);
        check_levels("skip");
        show(7'h12, 10);
        check_levels("illegal");
        show(glyph[5], 10);
        check_levels("after_illegal");

        // Enable low while the display changes to 3.
        en = 1'b0;
        seg_in = glyph[3];
        repeat (12) @(negedge clk);
        check_levels("en_low");
        model_accept(glyph[3]);
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (update === 1'b1) break;
        end
        check("en_latency", n, STABLE);
        repeat (4) @(negedge clk);
        check_levels("en_high");

        // Reset in the middle of a candidate.
        seg_in = glyph[7];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_digit", int'(digit_out),   0);
        check("midrst_valid", int'(digit_valid), 0);
        check("midrst_steps", int'(step_count),  0);
        check("midrst_skip",  int'(skip_err),    0);
        model_reset();
        seg_in = 7'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_levels("post_rst");
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
